reg_writeback: RTL and testbench

- Write side of the 31-entry integer register file; the read port is the counterpart.
- Accepts write-back requests from the execute stage over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle to the register storage write port, which may stall via wr_ready.
- Exposes a forwarding lookup so rs1/rs2 reads see queued, not-yet-committed values.

---
 rtl/reg_writeback.sv | 124 ++++++++++++
 tb/tb_reg_writeback.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: in-order write-back queue feeding the register file write port.
// Build option WB_FORWARD_EN: multi-entry queueing plus rs1/rs2 forwarding lookup.
module reg_writeback #(
    parameter int DEPTH     = 2,
    parameter int XLEN      = 32,
    parameter int MC_WE_BIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             microcode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_addr,
    input  logic [XLEN-1:0]         in_data,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [4:0]              wr_addr,
    output logic [XLEN-1:0]         wr_data,
    input  logic [4:0]              fwd_rs1_addr,
    output logic                    fwd_rs1_hit,
    output logic [XLEN-1:0]         fwd_rs1_data,
    input  logic [4:0]              fwd_rs2_addr,
    output logic                    fwd_rs2_hit,
    output logic [XLEN-1:0]         fwd_rs2_data,
    output logic [$clog2(DEPTH):0]  pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      r_addr [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic w_req;
    logic w_acc;
    logic w_push;
    logic w_pop;
    logic w_unused_mc;

    assign w_unused_mc = ^microcode;

    assign w_req  = in_valid & microcode[MC_WE_BIT];
    assign w_acc  = w_req & in_ready;
    assign w_push = w_acc & (in_addr != 5'd0);
    assign w_pop  = wr_en & wr_ready;

`ifdef WB_FORWARD_EN
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    assign in_ready = (r_count < LP_DEPTH);
`else
    // Single outstanding write: readers stall instead of forwarding.
    assign in_ready = (r_count == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= in_addr;
                r_data[r_tail] <= in_data;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign pending = r_count;
    assign wr_en   = (r_count != '0);
    assign wr_addr = wr_en ? r_addr[r_head] : 5'd0;
    assign wr_data = wr_en ? r_data[r_head] : '0;

`ifdef WB_FORWARD_EN
    logic [PW-1:0] w_idx;

    // Walk oldest to newest so the newest match overwrites older ones.
    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs1_data = '0;
        fwd_rs2_hit  = 1'b0;
        fwd_rs2_data = '0;
        w_idx        = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if (fwd_rs1_addr != 5'd0 &&
                    r_addr[w_idx] == fwd_rs1_addr) begin
                    fwd_rs1_hit  = 1'b1;
                    fwd_rs1_data = r_data[w_idx];
                end
                if (fwd_rs2_addr != 5'd0 &&
                    r_addr[w_idx] == fwd_rs2_addr) begin
                    fwd_rs2_hit  = 1'b1;
                    fwd_rs2_data = r_data[w_idx];
                end
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{fwd_rs1_addr, fwd_rs2_addr};
    assign fwd_rs1_hit  = 1'b0;
    assign fwd_rs1_data = '0;
    assign fwd_rs2_hit  = 1'b0;
    assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: random and directed stimulus against a queue model.
// The model's capacity and forwarding follow the WB_FORWARD_EN build option.
`timescale 1ns/1ps
module tb_reg_writeback;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
`ifdef WB_FORWARD_EN
    localparam int CAP = DEPTH;
    localparam bit FWD = 1'b1;
`else
    localparam int CAP = 1;
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     microcode = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_addr = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            wr_en;
    logic            wr_ready = 1'b0;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [4:0]      fwd_rs1_addr = '0;
    logic            fwd_rs1_hit;
    logic [XLEN-1:0] fwd_rs1_data;
    logic [4:0]      fwd_rs2_addr = '0;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_rs2_data;
    logic [1:0]      pending;

    int checks   = 0;
    int failures = 0;

    logic [4:0]      q_addr[$];
    logic [XLEN-1:0] q_data[$];
    logic [4:0]      dut_log[$];

    reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN), .MC_WE_BIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .microcode(microcode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs1_hit(fwd_rs1_hit),
        .fwd_rs1_data(fwd_rs1_data),
        .fwd_rs2_addr(fwd_rs2_addr), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs2_data(fwd_rs2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic m_in_ready();
        return q_addr.size() < CAP;
    endfunction

    function automatic logic [1:0] m_pending();
        return 2'(q_addr.size());
    endfunction

    function automatic logic [4:0] m_wr_addr();
        return (q_addr.size() != 0) ? q_addr[0] : 5'd0;
    endfunction

    function automatic logic [XLEN-1:0] m_wr_data();
        return (q_data.size() != 0) ? q_data[0] : '0;
    endfunction

    function automatic logic m_hit(input logic [4:0] a);
        if (!FWD || a == 5'd0) return 1'b0;
        foreach (q_addr[i]) if (q_addr[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] m_fdata(input logic [4:0] a);
        if (!FWD || a == 5'd0) return '0;
        for (int i = q_addr.size() - 1; i >= 0; i--)
            if (q_addr[i] == a) return q_data[i];
        return '0;
    endfunction

    task automatic drive(input logic v, input logic [15:0] mc,
                         input logic [4:0] a, input logic [XLEN-1:0] d);
        in_valid  = v;
        microcode = mc;
        in_addr   = a;
        in_data   = d;
    endtask

    // One clock: model decides accept/pop from pre-edge inputs.
    task automatic tick();
        logic acc, pop;
        logic [4:0] a;
        logic [XLEN-1:0] d;
        acc = in_valid && microcode[3] && (q_addr.size() < CAP);
        pop = (q_addr.size() != 0) && wr_ready;
        a = in_addr;
        d = in_data;
        if (wr_en && wr_ready) dut_log.push_back(wr_addr);
        @(posedge clk);
        if (pop) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (acc && a != 5'd0) begin
            q_addr.push_back(a);
            q_data.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_ready = 1'b1;
        drive(1'b1, 16'h0008, 5'd9, 32'h5);
        fwd_rs1_addr = 5'd9;
        fwd_rs2_addr = 5'd9;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        checks++;
        if (wr_en !== 1'b0 || pending !== 2'd0) begin
            failures++;
            $display("FAIL reset_state wr_en=%0b pending=%0d exp 0/0",
                     wr_en, pending);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pending !== 2'd0 || fwd_rs1_hit !== 1'b0 || fwd_rs2_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold pending=%0d hit1=%0b hit2=%0b exp 0",
                     pending, fwd_rs1_hit, fwd_rs2_hit);
        end
        drive(1'b0, 16'h0, 5'd0, '0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_simple_drain();
        wr_ready = 1'b1;
        drive(1'b1, 16'h0008, 5'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_ready got=%0b exp=1", in_ready);
        end
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL drain_head en=%0b addr=%0d data=%h exp 1/5/deadbeef",
                     wr_en, wr_addr, wr_data);
        end
        tick();
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== '0) begin
            failures++;
            $display("FAIL drain_empty en=%0b addr=%0d data=%h exp 0/0/0",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_backpressure();
        wr_ready = 1'b0;
        drive(1'b1, 16'h0008, 5'd1, 32'hA1);
        #1;
        tick();
        drive(1'b1, 16'h0008, 5'd2, 32'hA2);
        #1;
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        #1;
        checks++;
        if (pending !== 2'((CAP >= 2) ? 2 : 1) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full pending=%0d ready=%0b exp %0d/0",
                     pending, in_ready, (CAP >= 2) ? 2 : 1);
        end
        repeat (3) begin
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'hA1) begin
                failures++;
                $display("FAIL bp_hold en=%0b addr=%0d data=%h exp 1/1/a1",
                         wr_en, wr_addr, wr_data);
            end
            tick();
            #1;
        end
        wr_ready = 1'b1;
        #1;
        repeat (3) begin
            checks++;
            if (pending !== m_pending() || wr_addr !== m_wr_addr() ||
                wr_en !== (q_addr.size() != 0)) begin
                failures++;
                $display("FAIL bp_drain pending=%0d addr=%0d exp %0d/%0d",
                         pending, wr_addr, m_pending(), m_wr_addr());
            end
            tick();
            #1;
        end
    endtask

    task automatic test_x0_gating();
        wr_ready = 1'b1;
        drive(1'b1, 16'h0008, 5'd0, 32'h1234);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready got=%0b exp=1", in_ready);
        end
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        #1;
        checks++;
        if (pending !== 2'd0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL x0_discard pending=%0d en=%0b exp 0/0", pending, wr_en);
        end
        drive(1'b1, 16'hFFF7, 5'd5, 32'h77);
        #1;
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        #1;
        checks++;
        if (pending !== 2'd0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL mc_gate pending=%0d en=%0b exp 0/0", pending, wr_en);
        end
    endtask

    task automatic test_forwarding();
        wr_ready = 1'b0;
        drive(1'b1, 16'h0008, 5'd7, 32'h11);
        #1;
        tick();
        drive(1'b1, 16'h0008, 5'd7, 32'h22);
        #1;
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        fwd_rs1_addr = 5'd7;
        fwd_rs2_addr = 5'd0;
        #1;
        checks++;
        if (fwd_rs1_hit !== FWD || fwd_rs1_data !== (FWD ? 32'h22 : 32'h0)) begin
            failures++;
            $display("FAIL fwd_newest hit=%0b data=%h exp %0b/%h",
                     fwd_rs1_hit, fwd_rs1_data, FWD, FWD ? 32'h22 : 32'h0);
        end
        checks++;
        if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== '0) begin
            failures++;
            $display("FAIL fwd_x0 hit=%0b data=%h exp 0/0", fwd_rs2_hit, fwd_rs2_data);
        end
        wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (fwd_rs1_hit !== m_hit(5'd7) || fwd_rs1_data !== m_fdata(5'd7)) begin
                failures++;
                $display("FAIL fwd_pop%0d hit=%0b data=%h exp %0b/%h", k,
                         fwd_rs1_hit, fwd_rs1_data, m_hit(5'd7), m_fdata(5'd7));
            end
            tick();
        end
    endtask

    task automatic test_push_pop_wrap();
        int nxt;
        logic acc;
        logic [4:0] exp_q[$];
        wr_ready = 1'b1;
        drive(1'b0, 16'h0, 5'd0, '0);
        for (int k = 0; k < 8 && q_addr.size() != 0; k++) tick();
        wr_ready = 1'b0;
        drive(1'b1, 16'h0008, 5'd20, 32'h2020);
        #1;
        tick();
        dut_log.delete();
        wr_ready = 1'b1;
        nxt = 1;
        for (int k = 0; k < 40 && nxt <= 8; k++) begin
            drive(1'b1, 16'h0008, 5'(nxt), $urandom);
            #1;
            checks++;
            if (pending !== m_pending() || in_ready !== m_in_ready()) begin
                failures++;
                $display("FAIL wrap_pending pending=%0d ready=%0b exp %0d/%0b",
                         pending, in_ready, m_pending(), m_in_ready());
            end
            acc = m_in_ready();
            tick();
            if (acc) nxt++;
        end
        checks++;
        if (nxt <= 8) begin
            failures++;
            $display("FAIL wrap_budget accepted=%0d exp 8", nxt - 1);
        end
        drive(1'b0, 16'h0, 5'd0, '0);
        for (int k = 0; k < 8 && (q_addr.size() != 0 || wr_en); k++) tick();
        exp_q.push_back(5'd20);
        for (int k = 1; k <= 8; k++) exp_q.push_back(5'(k));
        checks++;
        if (dut_log != exp_q) begin
            failures++;
            $display("FAIL wrap_order got=%p exp=%p", dut_log, exp_q);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'hFFF7)
                                               : (16'($urandom) | 16'h0008),
                  5'($urandom_range(0, 7)), $urandom);
            wr_ready     = ($urandom_range(0, 2) != 0);
            fwd_rs1_addr = 5'($urandom_range(0, 7));
            fwd_rs2_addr = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (in_ready !== m_in_ready() || pending !== m_pending()) begin
                failures++;
                $display("FAIL rnd_ctrl@%0d ready=%0b pending=%0d exp %0b/%0d",
                         k, in_ready, pending, m_in_ready(), m_pending());
            end
            checks++;
            if (wr_en !== (q_addr.size() != 0) || wr_addr !== m_wr_addr() ||
                wr_data !== m_wr_data()) begin
                failures++;
                $display("FAIL rnd_wr@%0d en=%0b addr=%0d data=%h exp %0d/%h",
                         k, wr_en, wr_addr, wr_data, m_wr_addr(), m_wr_data());
            end
            checks++;
            if (fwd_rs1_hit !== m_hit(fwd_rs1_addr) ||
                fwd_rs1_data !== m_fdata(fwd_rs1_addr)) begin
                failures++;
                $display("FAIL rnd_fwd1@%0d a=%0d hit=%0b data=%h exp %0b/%h",
                         k, fwd_rs1_addr, fwd_rs1_hit, fwd_rs1_data,
                         m_hit(fwd_rs1_addr), m_fdata(fwd_rs1_addr));
            end
            checks++;
            if (fwd_rs2_hit !== m_hit(fwd_rs2_addr) ||
                fwd_rs2_data !== m_fdata(fwd_rs2_addr)) begin
                failures++;
                $display("FAIL rnd_fwd2@%0d a=%0d hit=%0b data=%h exp %0b/%h",
                         k, fwd_rs2_addr, fwd_rs2_hit, fwd_rs2_data,
                         m_hit(fwd_rs2_addr), m_fdata(fwd_rs2_addr));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        wr_ready = 1'b0;
        drive(1'b1, 16'h0008, 5'd3, 32'h33);
        #1;
        tick();
        drive(1'b1, 16'h0008, 5'd4, 32'h44);
        #1;
        tick();
        drive(1'b0, 16'h0, 5'd0, '0);
        fwd_rs1_addr = 5'd3;
        fwd_rs2_addr = 5'd4;
        #3;
        rst_n = 1'b0;
        #1;
        q_addr.delete();
        q_data.delete();
        checks++;
        if (wr_en !== 1'b0 || pending !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state en=%0b pending=%0d ready=%0b exp 0/0/1",
                     wr_en, pending, in_ready);
        end
        checks++;
        if (fwd_rs1_hit !== 1'b0 || fwd_rs2_hit !== 1'b0 ||
            fwd_rs1_data !== '0 || fwd_rs2_data !== '0) begin
            failures++;
            $display("FAIL midrst_fwd hit1=%0b hit2=%0b exp 0/0",
                     fwd_rs1_hit, fwd_rs2_hit);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        dut_log.delete();
        repeat (4) begin
            #1;
            checks++;
            if (wr_en !== 1'b0 || pending !== 2'd0) begin
                failures++;
                $display("FAIL midrst_stale en=%0b addr=%0d pending=%0d exp 0",
                         wr_en, wr_addr, pending);
            end
            tick();
        end
        checks++;
        if (dut_log.size() != 0) begin
            failures++;
            $display("FAIL midrst_commits got=%0d exp=0", dut_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_simple_drain();
        test_backpressure();
        test_x0_gating();
        test_forwarding();
        test_push_pop_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
